// File: rtl/channel_scan_sequencer_pkg.sv
// rtl/channel_scan_sequencer_pkg.sv - shared state encodings and constants for the channel scan sequencer
// Contents: scan_state_e (IDLE/BLANK/DWELL), NUM_CH, cnt_width() slot-counter sizing helper.
package channel_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } scan_state_e;

  localparam int NUM_CH = 4;

  // Counter must hold the largest terminal count of either phase.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/channel_scan_sequencer_rr_next_channel.sv
// rtl/channel_scan_sequencer_rr_next_channel.sv - combinational round-robin next-channel search
// Ports:
//   cur   [1:0] in  - current channel; search starts at cur+1 and wraps
//   mask  [3:0] in  - participating channels
//   nxt   [1:0] out - next set bit after cur (cur itself only if it is the sole set bit)
//   valid       out - mask has at least one set bit
module rr_next_channel
  import channel_scan_sequencer_pkg::*;
(
  input  logic [1:0] cur,
  input  logic [3:0] mask,
  output logic [1:0] nxt,
  output logic       valid
);

  logic [1:0] idx;

  // Walk from farthest (cur+4 == cur) to nearest (cur+1) so the nearest hit wins.
  always_comb begin
    nxt   = cur;
    valid = 1'b0;
    idx   = 2'd0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (mask[idx]) begin
        nxt   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_scan_sequencer.sv
// rtl/channel_scan_sequencer.sv - round-robin channel scan sequencer driving a 1-to-4 demux
// Ports:
//   clk            in  - clock, rising edge
//   rst_n          in  - asynchronous active-low reset
//   run            in  - 1 = sequence channels, 0 = stop
//   ch_mask  [3:0] in  - channels taking part in the scan
//   sel      [1:0] out - demux channel select (registered)
//   enable         out - demux enable (registered)
//   slot_start     out - pulse on first enabled cycle of each slot (registered)
//   busy           out - state is not IDLE (registered)
module channel_scan_sequencer
  import channel_scan_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] ch_mask,
  output logic [1:0] sel,
  output logic       enable,
  output logic       slot_start,
  output logic       busy
);

  localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // With no blanking a slot begins directly in DWELL.
  localparam scan_state_e SLOT_ENTRY = (BLANK_CYCLES > 0) ? BLANK : DWELL;
  localparam logic ENTRY_IS_DWELL = (BLANK_CYCLES > 0) ? 1'b0 : 1'b1;

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, ss_q, ss_d, busy_q;
  logic [1:0]       rr_cur;
  logic [1:0]       rr_nxt;
  logic             rr_valid;

  // From IDLE, searching after channel 3 yields the lowest set bit.
  assign rr_cur = (state_q == IDLE) ? 2'd3 : sel_q;

  rr_next_channel u_rr (
    .cur   (rr_cur),
    .mask  (ch_mask),
    .nxt   (rr_nxt),
    .valid (rr_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ss_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run && rr_valid) begin
          sel_d   = rr_nxt;
          state_d = SLOT_ENTRY;
          cnt_d   = '0;
          ss_d    = ENTRY_IS_DWELL;
        end
      end
      BLANK: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = DWELL;
          cnt_d   = '0;
          ss_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DWELL: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          // Slot boundary: ch_mask is only looked at here and on IDLE exit.
          cnt_d = '0;
          if (rr_valid) begin
            sel_d   = rr_nxt;
            state_d = SLOT_ENTRY;
            ss_d    = ENTRY_IS_DWELL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      ss_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= (state_d == DWELL);
      ss_q    <= ss_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign sel        = sel_q;
  assign enable     = en_q;
  assign slot_start = ss_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// tb/tb_channel_scan_sequencer.sv - self-checking bench for channel_scan_sequencer
module tb_channel_scan_sequencer;

  localparam int DW = 3;
  localparam int BL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic [1:0] sel;
  logic       enable, slot_start, busy;

  int checks = 0;
  int failures = 0;

  channel_scan_sequencer #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .ch_mask    (ch_mask),
    .sel        (sel),
    .enable     (enable),
    .slot_start (slot_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each slot is a precomputed list of expected output cycles.
  // Entry = {sel[1:0], enable, slot_start}.
  logic [3:0] slot_q[$];
  logic [1:0] m_sel;
  logic       m_en, m_ss, m_busy, m_active;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [1:0] next_after(input logic [1:0] c, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(int'(c) + k) % 4]) return 2'((int'(c) + k) % 4);
    return c;
  endfunction

  task automatic push_slot(input logic [1:0] ch);
    for (int i = 0; i < BL; i++) slot_q.push_back({ch, 1'b0, 1'b0});
    for (int i = 0; i < DW; i++) slot_q.push_back({ch, 1'b1, (i == 0)});
  endtask

  task automatic pop_slot();
    logic [3:0] e;
    e = slot_q.pop_front();
    m_sel = e[3:2]; m_en = e[1]; m_ss = e[0]; m_busy = 1'b1;
  endtask

  task automatic idle_out();
    m_en = 1'b0; m_ss = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_reset();
    slot_q.delete();
    m_active = 1'b0;
    m_sel = 2'd0;
    idle_out();
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (run && ch_mask != 4'b0) begin
        push_slot(lowest_bit(ch_mask));
        m_active = 1'b1;
        pop_slot();
      end else idle_out();
    end else if (!run) begin
      slot_q.delete();
      m_active = 1'b0;
      idle_out();
    end else if (slot_q.size() == 0) begin
      if (ch_mask == 4'b0) begin
        m_active = 1'b0;
        idle_out();
      end else begin
        push_slot(next_after(m_sel, ch_mask));
        pop_slot();
      end
    end else pop_slot();
  endtask

  task automatic check_outputs();
    check_eq("sel", int'(sel), int'(m_sel));
    check_eq("enable", int'(enable), int'(m_en));
    check_eq("slot_start", int'(slot_start), int'(m_ss));
    check_eq("busy", int'(busy), int'(m_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic wait_slot_start(input logic [1:0] ch, input string tag);
    int n;
    n = 0;
    while (!(m_ss && m_sel == ch) && n < 60) begin
      tick();
      n++;
    end
    check_eq(tag, int'(n < 60), 1);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "_sel"}, int'(sel), 0);
    check_eq({tag, "_enable"}, int'(enable), 0);
    check_eq({tag, "_slot_start"}, int'(slot_start), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_sel", int'(sel), 0);
    check_eq("rst_enable", int'(enable), 0);
    check_eq("rst_slot_start", int'(slot_start), 0);
    check_eq("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // run=1 with empty mask stays idle
    run = 1'b1; ch_mask = 4'b0000;
    repeat (4) tick();
    check_eq("idle_empty_mask_busy", int'(busy), 0);

    // Full mask: 0,1,2,3,0 with 2 low / 3 high per slot
    ch_mask = 4'b1111;
    repeat (30) tick();

    // Alternating mask: channels 0 and 2 must never appear while enabled
    ch_mask = 4'b1010;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (enable && (sel == 2'd0 || sel == 2'd2) && i > 10) bad++;
    end
    check_eq("mask1010_excluded", bad, 0);

    // Single channel repeats indefinitely
    ch_mask = 4'b0100;
    repeat (25) tick();
    check_eq("single_sel", int'(sel), 2);

    // Run dropped on 2nd DWELL cycle of channel 1
    run = 1'b0; tick();
    run = 1'b1; ch_mask = 4'b1111;
    wait_slot_start(2'd1, "wait_ch1");
    tick();
    run = 1'b0;
    tick();
    check_eq("drop_enable", int'(enable), 0);
    check_eq("drop_busy", int'(busy), 0);
    check_eq("drop_sel", int'(sel), 1);
    repeat (3) tick();

    // Mask cleared mid-DWELL: slot completes, then idle
    run = 1'b1; ch_mask = 4'b1111;
    wait_slot_start(2'd2, "wait_ch2");
    ch_mask = 4'b0000;
    tick();
    check_eq("mask0_still_en2", int'(enable), 1);
    tick();
    check_eq("mask0_still_en3", int'(enable), 1);
    tick();
    check_eq("mask0_enable_off", int'(enable), 0);
    check_eq("mask0_idle", int'(busy), 0);
    repeat (3) tick();

    // Async reset mid-DWELL, restart at lowest set bit
    ch_mask = 4'b0110;
    wait_slot_start(2'd2, "wait_rst_ch2");
    tick();
    async_reset_pulse("async_rst");
    tick();
    check_eq("restart_sel", int'(sel), 1);
    repeat (8) tick();

    // Randomised run/mask traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom_range(0, 15));
      run = ($urandom_range(0, 19) != 0);
      if (i == 700) async_reset_pulse("rand_rst");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
